// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count,
// default payload width and the channel-select type.
package demux_pkg;

    localparam int NUM_CH     = 4;
    localparam int DATA_W_DEF = 8;

    typedef logic [1:0] ch_sel_t;

endpackage : demux_pkg

// File: rtl/chan_fifo.sv
// Single-channel FIFO with occupancy count; head entry reads as zero when empty.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module chan_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic [DATA_W-1:0] head_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign count     = count_r;
    assign rdata     = head_s;

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Head entry, forced to zero while the channel holds nothing.
    always_comb begin
        head_s = {DATA_W{1'b0}};
        if (empty) begin
            head_s = {DATA_W{1'b0}};
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

endmodule : chan_fifo

// File: rtl/demux1to4_stream.sv
// Routes one input stream to four independently back-pressured output channels,
// each buffered by its own chan_fifo.
module demux1to4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  ch_sel_t           in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] empty_s;
    logic [NUM_CH-1:0] full_s;
    logic [CW-1:0]     count_s [NUM_CH];
    logic [DATA_W-1:0] data_s  [NUM_CH];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign push_s[ch] = in_valid && (in_sel == ch_sel_t'(ch)) && !full_s[ch];

        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_s[ch]),
            .pop   (out_ready[ch]),
            .wdata (in_data),
            .rdata (data_s[ch]),
            .count (count_s[ch]),
            .empty (empty_s[ch]),
            .full  (full_s[ch])
        );
    end

    // Readiness depends only on the selected channel's registered count, never on out_ready.
    assign in_ready  = (count_s[in_sel] < CW'(DEPTH));
    assign out_valid = ~empty_s;
    assign busy      = |out_valid;
    assign out_data0 = data_s[0];
    assign out_data1 = data_s[1];
    assign out_data2 = data_s[2];
    assign out_data3 = data_s[3];

endmodule : demux1to4_stream

// File: tb/tb_demux1to4_stream.sv
// Bench for demux1to4_stream: directed vector table, reset/streaming sequences
// and randomized traffic, all checked against a queue-based channel model.
module tb_demux1to4_stream;

    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic          busy;
    logic [DW-1:0] od [4];

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mq [4][$];

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] ordy;
        logic [3:0] eov;
        logic       eir;
        logic [1:0] cch;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl [15];

    demux1to4_stream #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against the queue model for the inputs currently applied.
    task automatic model_check();
        logic [3:0] eov;
        for (int i = 0; i < 4; i++) begin
            eov[i] = (mq[i].size() != 0);
            check($sformatf("model_data%0d", i), 32'(od[i]),
                  (mq[i].size() != 0) ? 32'(mq[i][0]) : 32'd0);
        end
        check("model_out_valid", 32'(out_valid), 32'(eov));
        check("model_busy", 32'(busy), 32'(eov != 4'b0000));
        check("model_in_ready", 32'(in_ready), 32'(mq[in_sel].size() < DEPTH));
    endtask

    task automatic model_update(input logic r, input logic v, input logic [1:0] s,
                                input logic [7:0] d, input logic [3:0] ordy);
        logic acc;
        if (r) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
        end else begin
            acc = v && (mq[s].size() < DEPTH);
            for (int i = 0; i < 4; i++) begin
                if (ordy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
            end
            if (acc) mq[s].push_back(d);
        end
    endtask

    // Apply inputs at the falling edge, check, then clock and advance the model.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [7:0] d, input logic [3:0] ordy);
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
        #1;
        model_check();
        @(posedge clk);
        model_update(r, v, s, d, ordy);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hFF; out_ready = 4'b0000;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        //          r     v     sel   d      ordy     eov      eir   cch   ed
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'b0000, 4'b0000, 1'b1, 2'd2, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0100, 1'b1, 2'd2, 8'hA5};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 8'h11, 4'b0000, 4'b0100, 1'b1, 2'd1, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 8'h22, 4'b0000, 4'b0110, 1'b1, 2'd1, 8'h11};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 8'h33, 4'b0000, 4'b0110, 1'b0, 2'd1, 8'h11};
        tbl[6]  = '{1'b0, 1'b1, 2'd1, 8'h33, 4'b0010, 4'b0110, 1'b0, 2'd1, 8'h11};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 8'h33, 4'b0010, 4'b0110, 1'b1, 2'd1, 8'h22};
        tbl[8]  = '{1'b0, 1'b0, 2'd1, 8'h00, 4'b0000, 4'b0110, 1'b1, 2'd1, 8'h33};
        tbl[9]  = '{1'b0, 1'b0, 2'd2, 8'h00, 4'b0100, 4'b0110, 1'b1, 2'd2, 8'hA5};
        tbl[10] = '{1'b0, 1'b1, 2'd0, 8'h01, 4'b0000, 4'b0010, 1'b1, 2'd0, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 2'd0, 8'h02, 4'b0001, 4'b0011, 1'b1, 2'd0, 8'h01};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0011, 1'b1, 2'd0, 8'h02};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0011, 4'b0011, 1'b1, 2'd0, 8'h02};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1, 2'd1, 8'h00};

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].r; in_valid = tbl[i].v; in_sel = tbl[i].sel;
            in_data = tbl[i].d; out_ready = tbl[i].ordy;
            #1;
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].eov != 4'b0000));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
            check($sformatf("vec%0d_data", i), 32'(od[tbl[i].cch]), 32'(tbl[i].ed));
            model_check();
            @(posedge clk);
            model_update(tbl[i].r, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy);
            @(negedge clk);
        end

        // Fill every channel, then a single reset cycle must discard it all.
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 2'(k % 4), 8'(8'hC0 + k), 4'b0000);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
        check("fill_out_valid", 32'(out_valid), 32'hF);
        step(1'b1, 1'b1, 2'd3, 8'hEE, 4'b1111);
        check("post_rst_out_valid", 32'(out_valid), 32'h0);
        check("post_rst_data0", 32'(out_data0), 32'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2'(k), 8'(8'h50 + k), 4'b0000);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);

        // Round-robin streaming with all consumers ready; in_ready must never drop.
        for (int k = 0; k < 256; k++) begin
            rst = 1'b0; in_valid = 1'b1; in_sel = 2'(k % 4); in_data = 8'(k); out_ready = 4'b1111;
            #1;
            check("stream_in_ready", 32'(in_ready), 32'd1);
            model_check();
            @(posedge clk);
            model_update(1'b0, 1'b1, 2'(k % 4), 8'(k), 4'b1111);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);

        // Randomized traffic with occasional reset.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), 2'($urandom),
                 8'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_demux1to4_stream
